// File: rtl/mont_domain_converter.sv
// Streaming converter between the normal and Montgomery domains for q = 3329, R = 2^16.
// TO_MONT multiplies by R^2 mod q, FROM_MONT by 1; both then run one Montgomery
// reduction, so the result is a*R mod q or a*R^-1 mod q respectively. The pipeline
// holds three compute stages plus the output register, and the whole pipe moves as one.
module mont_domain_converter #(
    parameter int unsigned Q      = 3329,
    parameter int unsigned QINV   = 62209,
    parameter int unsigned R2MODQ = 1353,
    parameter int unsigned CW     = 12,
    parameter int unsigned NCOEF  = 256
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [CW-1:0]            in_data,
    input  logic                     in_mode,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [CW-1:0]            out_data,
    output logic [$clog2(NCOEF)-1:0] out_idx,
    output logic                     out_last
);

    localparam int unsigned IW  = $clog2(NCOEF);
    localparam int unsigned PW  = 24;   // a * k < 4096 * 1353 < 2^23
    localparam int unsigned MQW = 28;   // m * Q < 2^16 * 3329 < 2^28
    localparam int unsigned TW  = 14;   // -Q < t < Q fits a signed 14-bit value

    localparam logic [15:0]          QINV_W = 16'(QINV);
    localparam logic [MQW-1:0]       Q_MQ   = MQW'(Q);
    localparam logic signed [TW-1:0] Q_T    = TW'(Q);

    typedef enum logic {
        TO_MONT   = 1'b0,
        FROM_MONT = 1'b1
    } mode_e;

    // Pipeline state: valid bits per stage and the payload each stage carries.
    logic                 v1_q, v2_q, v3_q, out_valid_q;
    logic [PW-1:0]        s1_p_q, s2_p_q;
    logic [15:0]          s2_m_q;
    logic signed [TW-1:0] s3_t_q;
    logic [CW-1:0]        out_data_q;
    logic [IW-1:0]        idx_q;

    // Next-state values computed by each stage.
    logic [PW-1:0]        s1_k;
    logic [PW-1:0]        s1_p_d;
    logic [15:0]          s2_m_d;
    logic [MQW-1:0]       s3_mq;
    logic signed [31:0]   s3_diff;
    logic signed [TW-1:0] s3_t_d;
    logic [CW-1:0]        out_data_d;
    logic [IW-1:0]        idx_d;
    logic                 adv;
    logic                 out_xfer;

    // The whole pipe moves unless the output beat is held by downstream.
    assign adv      = !out_valid_q || out_ready;
    assign out_xfer = out_valid_q && out_ready;

    // S1: the mode only picks the constant; after this stage it is folded into p.
    assign s1_k   = (mode_e'(in_mode) == FROM_MONT) ? PW'(1) : PW'(R2MODQ);
    assign s1_p_d = PW'(in_data) * s1_k;

    // S2: m = p * q^-1 mod 2^16; the 16-bit context truncates the product.
    assign s2_m_d = s2_lo(s1_p_q) * QINV_W;

    // S3: p - m*q has its low 16 bits cleared, so the arithmetic shift is exact.
    assign s3_mq   = MQW'(s2_m_q) * Q_MQ;
    assign s3_diff = $signed(32'(s2_p_q)) - $signed(32'(s3_mq));
    assign s3_t_d  = TW'(s3_diff >>> 16);

    // Output: fold the signed remainder into the canonical range 0..Q-1.
    assign out_data_d = CW'(s3_t_q[TW-1] ? s3_t_q + Q_T : s3_t_q);

    function automatic logic [15:0] s2_lo(input logic [PW-1:0] p);
        return p[15:0];
    endfunction

    // Coefficient index advances once per accepted output beat and wraps at NCOEF.
    // NOTE: idx_d gets its hold value first so every path assigns it and no latch is inferred.
    always_comb begin
        idx_d = idx_q;
        if (out_xfer) begin
            idx_d = idx_q + IW'(1);
        end
    end

    // Control state: valid bits, output data and index, cleared by synchronous reset.
    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            v3_q        <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            idx_q       <= '0;
        end else begin
            if (adv) begin
                v1_q        <= in_valid;
                v2_q        <= v1_q;
                v3_q        <= v2_q;
                out_valid_q <= v3_q;
                out_data_q  <= out_data_d;
            end
            idx_q <= idx_d;
        end
    end

    // Intermediate datapath registers advance with the pipe.
    // NOTE: these carry no reset; the stage valid bits already mark their contents as meaningless.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_p_q <= s1_p_d;
            s2_p_q <= s1_p_q;
            s2_m_q <= s2_m_d;
            s3_t_q <= s3_t_d;
        end
    end

    assign in_ready  = adv;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_idx   = idx_q;
    assign out_last  = out_valid_q && (idx_q == IW'(NCOEF - 1));

endmodule
